// File: rtl/bus_rr_scheduler_pkg.sv
// ============================================================================
// Module      : bus_sched_pkg
// Description : Shared types and defaults for the bus round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_sched_pkg;

  // Scheduler FSM states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  localparam int c_default_nreq     = 2;
  localparam int c_default_lock_tmo = 1024;

endpackage

`default_nettype wire

// File: rtl/bus_rr_scheduler_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority encoder. Returns the first
//               set request at or after ptr, wrapping modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            valid
);

  // Requests rotated so that bit 0 corresponds to the pointer position
  logic [NREQ-1:0] w_rot;
  int              w_sum;

  // Scan the rotated vector from offset 0 and map the first hit back to an index
  always_comb begin
    w_rot = NREQ'({req, req} >> ptr);
    w_sum = 0;
    valid = 1'b0;
    id    = '0;
    gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && w_rot[i]) begin
        valid = 1'b1;
        w_sum = int'(ptr) + i;
        if (w_sum >= NREQ) begin
          w_sum = w_sum - NREQ;
        end
        id  = IDW'(w_sum);
        gnt = NREQ'(1) << id;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_rr_scheduler.sv
// ============================================================================
// Module      : bus_rr_scheduler
// Description : Round-robin scheduler for the shared DRAM/peripheral path.
//               Sequences each grant through issue/busy/done and supports a
//               bus lock for back-to-back atomic sequences.
//               Optional lock watchdog: define BUS_LOCK_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int NREQ     = c_default_nreq,
  parameter int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int LOCK_TMO = c_default_lock_tmo
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  logic            sys_busy,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            start,
  output logic [NREQ-1:0] done,
  output logic            locked,
  output logic            err,
  output logic            wdt_fire
);

  sched_state_t    r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_owner;

  logic [NREQ-1:0] w_owner_mask;
  logic [NREQ-1:0] w_cand;
  logic [NREQ-1:0] w_pick_gnt;
  logic [IDW-1:0]  w_pick_id;
  logic            w_pick_valid;

`ifdef BUS_LOCK_WDT_EN
  localparam int                  c_wdt_w   = (LOCK_TMO > 2) ? $clog2(LOCK_TMO) : 1;
  localparam logic [c_wdt_w-1:0]  c_wdt_max = c_wdt_w'(LOCK_TMO - 1);
  logic [c_wdt_w-1:0]             r_wdt_cnt;
`else
  assign wdt_fire = 1'b0;
`endif

  // The requester just completed is masked for one cycle so it may drop req
  // on its done cycle; a held lock narrows the candidates to the owner.
  assign w_owner_mask = NREQ'(1) << r_owner;
  assign w_cand       = req & ~done & (locked ? w_owner_mask : {NREQ{1'b1}});

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req   (w_cand),
    .ptr   (r_ptr),
    .gnt   (w_pick_gnt),
    .id    (w_pick_id),
    .valid (w_pick_valid)
  );

  // Scheduler FSM with registered grant, strobes, lock tracking and watchdog
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      gnt       <= NREQ'(1);
      gnt_id    <= '0;
      start     <= 1'b0;
      done      <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
`ifdef BUS_LOCK_WDT_EN
      wdt_fire  <= 1'b0;
      r_wdt_cnt <= '0;
`endif
    end else begin
      start <= 1'b0;
      done  <= '0;
`ifdef BUS_LOCK_WDT_EN
      wdt_fire <= 1'b0;
`endif
      // Downstream must be quiet while nothing is issued
      if (r_state == IDLE && sys_busy) begin
        err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            gnt     <= w_pick_gnt;
            gnt_id  <= w_pick_id;
            start   <= 1'b1;
            r_state <= ISSUE;
`ifdef BUS_LOCK_WDT_EN
            r_wdt_cnt <= '0;
`endif
          end
`ifdef BUS_LOCK_WDT_EN
          else if (locked && !req[r_owner]) begin
            if (r_wdt_cnt == c_wdt_max) begin
              locked    <= 1'b0;
              wdt_fire  <= 1'b1;
              r_wdt_cnt <= '0;
            end else begin
              r_wdt_cnt <= r_wdt_cnt + c_wdt_w'(1);
            end
          end
`endif
        end
        ISSUE: begin
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (sys_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!sys_busy) begin
            done    <= gnt;
            r_ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            locked  <= lock[gnt_id];
            r_owner <= gnt_id;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_scheduler.sv
// ============================================================================
// Module      : tb_bus_rr_scheduler
// Description : Scoreboard bench for bus_rr_scheduler (NREQ=2, LOCK_TMO=16).
//               Watchdog checks follow BUS_LOCK_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_rr_scheduler;

  localparam int NREQ     = 2;
  localparam int IDW      = 1;
  localparam int LOCK_TMO = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] lock = '0;
  logic            sys_busy = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            start;
  logic [NREQ-1:0] done;
  logic            locked;
  logic            err;
  logic            wdt_fire;

  bus_rr_scheduler #(
    .NREQ     (NREQ),
    .IDW      (IDW),
    .LOCK_TMO (LOCK_TMO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .lock     (lock),
    .sys_busy (sys_busy),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .start    (start),
    .done     (done),
    .locked   (locked),
    .err      (err),
    .wdt_fire (wdt_fire)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;

  int              gq[$];
  logic [NREQ-1:0] dq[$];

  int ds_delay = 1;
  int ds_len = 1;
  int ds_start_cyc = 0;
  int ds_fall_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream model: busy rises ds_delay cycles after start, lasts ds_len
  initial forever begin
    @(negedge CLK);
    if (start === 1'b1) begin
      ds_start_cyc = cyc;
      repeat (ds_delay) @(negedge CLK);
      sys_busy = 1'b1;
      repeat (ds_len) @(negedge CLK);
      sys_busy = 1'b0;
      ds_fall_cyc = cyc;
    end
  end

  // Monitor: pops expected grants on start and expected done vectors on done
  initial forever begin
    @(negedge CLK);
    if (start === 1'b1) begin
      n_start++;
      if (gq.size() == 0) begin
        chk("unexpected_start", {31'd0, start}, 32'd0);
      end else begin
        int e;
        e = gq.pop_front();
        chk("grant_id", {31'd0, gnt_id}, e);
        chk("grant_onehot", {30'd0, gnt}, 32'(1 << e));
      end
    end
    if (done !== '0) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", {30'd0, done}, 32'd0);
      end else begin
        logic [NREQ-1:0] d;
        d = dq.pop_front();
        chk("done_vec", {30'd0, done}, {30'd0, d});
      end
    end
  end

  task automatic do_reset();
    RST  = 1'b1;
    req  = '0;
    lock = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_done(input logic [NREQ-1:0] m, output int c);
    bit hit;
    hit = 1'b0;
    c = -1;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge CLK);
      if ((done & m) != '0) begin
        hit = 1'b1;
        c = cyc;
      end
    end
    if (!hit) chk("done_timeout", {30'd0, done & m}, {30'd0, m});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},      {30'd0, gnt},    32'd1);
    chk({tag, "_gnt_id"},   {31'd0, gnt_id}, 32'd0);
    chk({tag, "_start"},    {31'd0, start},  32'd0);
    chk({tag, "_done"},     {30'd0, done},   32'd0);
    chk({tag, "_locked"},   {31'd0, locked}, 32'd0);
    chk({tag, "_err"},      {31'd0, err},    32'd0);
    chk({tag, "_wdt_fire"}, {31'd0, wdt_fire}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  initial begin
    int r_cyc;
    int d_cyc;
    int n0;
    bit seen;

    // Reset state
    repeat (2) @(negedge CLK);
    chk_reset_vals("reset");
    RST = 1'b0;

    // Single request: busy 2 cycles after start for 3 cycles
    do_reset();
    ds_delay = 2;
    ds_len = 3;
    gq.push_back(0);
    dq.push_back(2'b01);
    req = 2'b01;
    r_cyc = cyc;
    wait_done(2'b01, d_cyc);
    req = '0;
    chk("start_latency", 32'(ds_start_cyc - r_cyc), 32'd1);
    chk("done_after_fall", 32'(d_cyc - ds_fall_cyc), 32'd1);
    repeat (3) @(negedge CLK);
    chk("gnt_id_hold_idle", {31'd0, gnt_id}, 32'd0);
    chk("gnt_hold_idle", {30'd0, gnt}, 32'd1);

    // Contention: 0,1,0,1 with minimum-latency downstream
    do_reset();
    ds_delay = 1;
    ds_len = 1;
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    dq.push_back(2'b01); dq.push_back(2'b10); dq.push_back(2'b01); dq.push_back(2'b10);
    req = 2'b11;
    for (int t = 0; t < 4; t++) wait_done(2'b11, d_cyc);
    req = '0;
    repeat (4) @(negedge CLK);

    // Lock: owner 0 gets two back-to-back grants despite req[1]
    do_reset();
    gq.push_back(0); gq.push_back(0); gq.push_back(1);
    dq.push_back(2'b01); dq.push_back(2'b01); dq.push_back(2'b10);
    req = 2'b11;
    lock = 2'b01;
    wait_done(2'b01, d_cyc);
    lock = 2'b00;
    chk("lock_taken", {31'd0, locked}, 32'd1);
    wait_done(2'b01, d_cyc);
    req = 2'b10;
    chk("lock_released", {31'd0, locked}, 32'd0);
    wait_done(2'b10, d_cyc);
    req = '0;
    repeat (3) @(negedge CLK);

    // Protocol error: busy while idle is sticky until reset
    do_reset();
    chk("err_clear", {31'd0, err}, 32'd0);
    sys_busy = 1'b1;
    @(negedge CLK);
    sys_busy = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    repeat (3) @(negedge CLK);
    chk("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("err_reset", {31'd0, err}, 32'd0);

    // Lock held by an idle owner while requester 1 waits
    do_reset();
    gq.push_back(0);
    dq.push_back(2'b01);
    req = 2'b11;
    lock = 2'b01;
    wait_done(2'b01, d_cyc);
    req = 2'b10;
    lock = 2'b00;
    chk("idle_owner_locked", {31'd0, locked}, 32'd1);
`ifdef BUS_LOCK_WDT_EN
    gq.push_back(1);
    dq.push_back(2'b10);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k < 16) begin
        chk("wdt_early", {31'd0, wdt_fire}, 32'd0);
      end else begin
        chk("wdt_fire", {31'd0, wdt_fire}, 32'd1);
        chk("wdt_unlock", {31'd0, locked}, 32'd0);
      end
    end
    @(negedge CLK);
    chk("wdt_pulse_width", {31'd0, wdt_fire}, 32'd0);
    chk("wdt_next_start", {31'd0, start}, 32'd1);
    chk("wdt_next_gnt", {31'd0, gnt_id}, 32'd1);
    wait_done(2'b10, d_cyc);
    req = '0;
`else
    n0 = n_start;
    repeat (40) @(negedge CLK);
    chk("blocked_no_start", 32'(n_start - n0), 32'd0);
    chk("lock_still_held", {31'd0, locked}, 32'd1);
    chk("wdt_tied_low", {31'd0, wdt_fire}, 32'd0);
`endif

    // Reset during WAIT_DONE while locked
    do_reset();
    ds_delay = 1;
    ds_len = 8;
    gq.push_back(0);
    dq.push_back(2'b01);
    req = 2'b01;
    lock = 2'b01;
    wait_done(2'b01, d_cyc);
    chk("pre_abort_locked", {31'd0, locked}, 32'd1);
    gq.push_back(0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (start === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("abort_start_timeout", {31'd0, start}, 32'd1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    req = '0;
    lock = '0;
    @(negedge CLK);
    chk_reset_vals("abort");
    for (int k = 0; k < 20 && sys_busy; k++) @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("abort_no_err", {31'd0, err}, 32'd0);

    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("done_queue_drained", 32'(dq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_rr_scheduler.md
# bus_rr_scheduler

Round-robin scheduler that shares the single DRAM/peripheral data path between NREQ core-side requesters. It sequences each granted transaction through an issue/busy/done handshake with the downstream system and supports a bus lock so that atomic (AMO) read-modify-write sequences run back-to-back without interleaving. It sits between the per-core bus ports and the shared memory/peripheral mux and drives the grant index that steers that mux.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- IDW, $clog2(NREQ) (min 1), width of the grant index
- LOCK_TMO, 1024, idle cycles allowed while a lock is held before the watchdog breaks it (watchdog builds only)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req  in  NREQ  level request per requester, held until its done pulse
- lock  in  NREQ  requester keeps the bus after its current transaction; sampled at completion
- sys_busy  in  1  OR of downstream busy (DRAM, UART tx not ready, data busy)
- gnt  out  NREQ  one-hot grant; steers the shared mux
- gnt_id  out  IDW  binary index of gnt
- start  out  1  one-cycle issue strobe to the downstream
- done  out  NREQ  one-cycle completion pulse to the granted requester
- locked  out  1  bus lock currently held
- err  out  1  sticky: sys_busy seen high while IDLE
- wdt_fire  out  1  one-cycle pulse when the watchdog breaks a lock (0 when watchdog not built)

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: candidate set = req & ~done_r. If locked, the set is further masked to the lock owner. If the set is non-empty: pick the first set bit at or after ptr, wrapping modulo NREQ; load gnt/gnt_id; go to ISSUE.
- ISSUE: start=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: stay until sys_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until sys_busy=0. On that edge:
  - done[gnt_id]=1 for the next cycle.
  - ptr <= gnt_id+1 mod NREQ.
  - If lock[gnt_id]=1: locked<=1, owner<=gnt_id. Otherwise locked<=0.
  - Go to IDLE.
- gnt and gnt_id hold their value from the load until the next arbitration, including all IDLE cycles.
- Only the owner can release a lock, by completing a transaction with lock=0. A locked owner that never requests blocks everyone else unless the watchdog is built.
- A sys_busy=1 sample in IDLE sets err. Arbitration proceeds regardless.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=1 (one-hot requester 0), gnt_id=0, start=0, done=0, locked=0, err=0, wdt_fire=0, watchdog counter=0.
- Reset mid-transaction aborts it: no done pulse is issued and the lock is cleared.
- Request latency: req sampled in IDLE at edge t gives gnt at t+1 and start during cycle t+1. Minimum per-transaction occupancy is 4 cycles (IDLE, ISSUE, WAIT_BUSY with busy high, WAIT_DONE with busy low).
- done is asserted in the first IDLE cycle after completion. In that cycle the same requester's req is ignored, so the requester may drop req on the done cycle.
- Simultaneous requests with ptr=0 grant index 0 first, then 1.
- A requester that is not locked and has a request pending is granted within NREQ-1 other transactions.

## Configuration
- BUS_LOCK_WDT_EN defined:
  - A counter increments each IDLE cycle while locked and req[owner]=0.
  - It clears on any grant.
  - When it reaches LOCK_TMO-1: locked<=0, wdt_fire pulses for one cycle, counter<=0.
- Undefined: no counter is built, the lock is held indefinitely, and wdt_fire is tied to 0.

## Structure
- Package bus_sched_pkg holds:
  - the state enum (2-bit encoding IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3);
  - the default NREQ and LOCK_TMO constants.
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs: request vector and pointer. Outputs: one-hot grant, index, valid.
- The FSM, lock and watchdog logic stay in the top module.

## Test plan
- Single request: req=01; downstream raises busy 2 cycles after start for 3 cycles → start 1 cycle after req, done[0] exactly one cycle after busy falls, gnt_id=0.
- Contention: req=11 held continuously → grant order 0,1,0,1 over 4 transactions, with no requester served twice in a row.
- Lock: requester 0 issues with lock=1 while req[1]=1 → two consecutive grants to 0; requester 1 is granted only after 0 completes with lock=0.
- Protocol error: sys_busy=1 in IDLE after reset → err=1 the next cycle and stays 1 until RST.
- Watchdog (BUS_LOCK_WDT_EN, LOCK_TMO=16): owner 0 locks then idles with req[1]=1 → wdt_fire pulses 16 IDLE cycles after done, locked falls, requester 1 granted the next cycle. Without the macro, requester 1 is never granted.
- Reset mid-transaction: RST asserted in WAIT_DONE while locked → all outputs at reset values the next cycle, no done pulse, locked=0.
